fp_hazard_u: RTL and testbench

- Producer-side companion to the FP WB-stage forwarding logic.
- Tracks FP destination registers written by in-flight multi-cycle FP operations: the fixed-latency FMA pipe and the iterative FDIV/FSQRT unit.
- Stalls ID on RAW/WAW hazards that WB forwarding cannot cover, and on write-port collisions or structural conflicts.
- Sits beside ID and drives the issue enables of the FP pipe and the divider.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_hazard_u_if.sv | 46 ++++
 rtl/fp_op_decode.sv | 43 ++++
 rtl/fp_hazard_u.sv | 110 +++++++++++
 tb/tb_fp_hazard_u.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP opcode/funct7 constants, op-class enum and register mask helper
//   Used by fp_op_decode, fp_hazard_u and the WB forwarding unit.
package fp_pkg;

  localparam logic [6:0] OP_FLW    = 7'b0000111;
  localparam logic [6:0] OP_FSW    = 7'b0100111;
  localparam logic [6:0] OP_FMADD  = 7'b1000011;
  localparam logic [6:0] OP_FMSUB  = 7'b1000111;
  localparam logic [6:0] OP_FNMSUB = 7'b1001011;
  localparam logic [6:0] OP_FNMADD = 7'b1001111;
  localparam logic [6:0] OP_FP     = 7'b1010011;

  localparam logic [6:0] F7_FADD     = 7'b0000000;
  localparam logic [6:0] F7_FSUB     = 7'b0000100;
  localparam logic [6:0] F7_FMUL     = 7'b0001000;
  localparam logic [6:0] F7_FDIV     = 7'b0001100;
  localparam logic [6:0] F7_FSQRT    = 7'b0101100;
  localparam logic [6:0] F7_FSGNJ    = 7'b0010000;
  localparam logic [6:0] F7_FMINMAX  = 7'b0010100;
  localparam logic [6:0] F7_FCMP     = 7'b1010000;
  localparam logic [6:0] F7_FCVT_W_S = 7'b1100000;
  localparam logic [6:0] F7_FCVT_S_W = 7'b1101000;
  localparam logic [6:0] F7_FMV_X_W  = 7'b1110000;
  localparam logic [6:0] F7_FMV_W_X  = 7'b1111000;

  typedef enum logic [1:0] {CLS_NONE, CLS_PIPE, CLS_ITER} op_cls_e;

  // One-hot register mask, empty when v is low.
  function automatic logic [31:0] reg_mask(input logic v, input logic [4:0] r);
    return {31'b0, v} << r;
  endfunction

endpackage

// File: rtl/fp_hazard_u_if.sv
// rtl/fp_hazard_u_if.sv - ID-side bus between the decode stage and fp_hazard_u
//   master: ID stage (drives instruction fields, receives stall/issue/status)
//   slave : fp_hazard_u
//   FP_HAZ_PERF_EN adds o_stall_cnt[31:0].
interface fp_hazard_u_if;
  logic        i_id_valid;
  logic        i_flush;
  logic [6:0]  i_opcode;
  logic [6:0]  i_funct7;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [4:0]  i_rs3;
  logic [4:0]  i_rd;
  logic        o_stall;
  logic        o_pipe_issue;
  logic        o_div_issue;
  logic        o_div_busy;
  logic        o_div_wb;
  logic [4:0]  o_div_rd;
  logic [31:0] o_pending;
`ifdef FP_HAZ_PERF_EN
  logic [31:0] o_stall_cnt;

  modport master (
    output i_id_valid, i_flush, i_opcode, i_funct7, i_rs1, i_rs2, i_rs3, i_rd,
    input  o_stall, o_pipe_issue, o_div_issue, o_div_busy, o_div_wb, o_div_rd,
           o_pending, o_stall_cnt
  );
  modport slave (
    input  i_id_valid, i_flush, i_opcode, i_funct7, i_rs1, i_rs2, i_rs3, i_rd,
    output o_stall, o_pipe_issue, o_div_issue, o_div_busy, o_div_wb, o_div_rd,
           o_pending, o_stall_cnt
  );
`else
  modport master (
    output i_id_valid, i_flush, i_opcode, i_funct7, i_rs1, i_rs2, i_rs3, i_rd,
    input  o_stall, o_pipe_issue, o_div_issue, o_div_busy, o_div_wb, o_div_rd,
           o_pending
  );
  modport slave (
    input  i_id_valid, i_flush, i_opcode, i_funct7, i_rs1, i_rs2, i_rs3, i_rd,
    output o_stall, o_pipe_issue, o_div_issue, o_div_busy, o_div_wb, o_div_rd,
           o_pending
  );
`endif
endinterface

// File: rtl/fp_op_decode.sv
// rtl/fp_op_decode.sv - combinational FP op class and operand-use decode
//   opcode, funct7 : ID instruction fields
//   cls            : CLS_PIPE (add/sub/mul/FMA), CLS_ITER (div/sqrt), CLS_NONE
//   use_rs1/2/3    : the register is read as an FP source
//   fp_rd          : rd names an FP destination
module fp_op_decode
  import fp_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output op_cls_e    cls,
  output logic       use_rs1,
  output logic       use_rs2,
  output logic       use_rs3,
  output logic       fp_rd
);

  logic is_fma;
  logic is_fp;

  assign is_fma = (opcode == OP_FMADD) || (opcode == OP_FMSUB) ||
                  (opcode == OP_FNMSUB) || (opcode == OP_FNMADD);
  assign is_fp  = (opcode == OP_FP);

  always_comb begin
    cls = CLS_NONE;
    if (is_fma || (is_fp && (funct7 inside {F7_FADD, F7_FSUB, F7_FMUL})))
      cls = CLS_PIPE;
    else if (is_fp && (funct7 inside {F7_FDIV, F7_FSQRT}))
      cls = CLS_ITER;

    // Integer-source converts/moves read x-registers through rs1.
    use_rs1 = is_fma || (is_fp && !(funct7 inside {F7_FCVT_S_W, F7_FMV_W_X}));
    use_rs2 = (opcode == OP_FSW) || is_fma ||
              (is_fp && (funct7 inside {F7_FADD, F7_FSUB, F7_FMUL, F7_FDIV,
                                        F7_FSGNJ, F7_FMINMAX, F7_FCMP}));
    use_rs3 = is_fma;
    // Compares, classify and FP->int moves/converts write x-registers.
    fp_rd   = (opcode == OP_FLW) || is_fma ||
              (is_fp && !(funct7 inside {F7_FCVT_W_S, F7_FMV_X_W, F7_FCMP}));
  end

endmodule

// File: rtl/fp_hazard_u.sv
// rtl/fp_hazard_u.sv - FP destination tracker and ID stall/issue control
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : ID instruction fields in; stall, pipe/div issue, divider
//                  busy/wb/rd and pending-destination mask out
//   FP_HAZ_PERF_EN adds a saturating stall-cycle counter on bus.o_stall_cnt.
module fp_hazard_u
  import fp_pkg::*;
#(
  parameter int PIPE_LAT = 3,
  parameter int DIV_LAT  = 12,
  parameter int SQRT_LAT = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  fp_hazard_u_if.slave bus
);

  localparam int MAX_LAT = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  op_cls_e cls;
  logic    use_rs1, use_rs2, use_rs3, fp_rd;

  fp_op_decode u_decode (
    .opcode (bus.i_opcode),
    .funct7 (bus.i_funct7),
    .cls    (cls),
    .use_rs1(use_rs1),
    .use_rs2(use_rs2),
    .use_rs3(use_rs3),
    .fp_rd  (fp_rd)
  );

  // Stage k holds the op issued k cycles ago; stage PIPE_LAT is its WB cycle.
  logic [PIPE_LAT:1] pipe_v;
  logic [4:0]        pipe_rd [1:PIPE_LAT];
  logic [CNT_W-1:0]  div_cnt;
  logic [4:0]        div_rd;

  logic [31:0] haz_mask;
  logic        id_live, div_late, raw, waw, stall, pipe_issue, div_issue;

  // WB-cycle entries are left out: forwarding covers them.
  always_comb begin
    haz_mask = reg_mask(div_cnt > CNT_W'(1), div_rd);
    for (int k = 1; k < PIPE_LAT; k++)
      haz_mask = haz_mask | reg_mask(pipe_v[k], pipe_rd[k]);
  end

  assign id_live  = bus.i_id_valid & ~bus.i_flush;
  assign div_late = div_cnt > CNT_W'(1);
  assign raw = (use_rs1 & haz_mask[bus.i_rs1]) |
               (use_rs2 & haz_mask[bus.i_rs2]) |
               (use_rs3 & haz_mask[bus.i_rs3]);
  assign waw = fp_rd & haz_mask[bus.i_rd];

  // A pipe op issued while cnt == PIPE_LAT+1 would reach WB together with
  // the divider result and fight for the single FP write port.
  assign stall = id_live & (raw | waw |
                            ((cls == CLS_ITER) & div_late) |
                            ((cls == CLS_PIPE) & (div_cnt == CNT_W'(PIPE_LAT + 1))));

  assign pipe_issue = id_live & ~stall & (cls == CLS_PIPE);
  assign div_issue  = id_live & ~stall & (cls == CLS_ITER);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pipe_v  <= '0;
      for (int k = 1; k <= PIPE_LAT; k++) pipe_rd[k] <= '0;
      div_cnt <= '0;
      div_rd  <= '0;
    end else begin
      pipe_v[1]  <= pipe_issue;
      pipe_rd[1] <= bus.i_rd;
      for (int k = 2; k <= PIPE_LAT; k++) begin
        pipe_v[k]  <= pipe_v[k-1];
        pipe_rd[k] <= pipe_rd[k-1];
      end
      // An issue on the WB cycle (cnt==1) reloads instead of decrementing.
      if (div_issue) begin
        div_cnt <= (bus.i_funct7 == F7_FSQRT) ? CNT_W'(SQRT_LAT) : CNT_W'(DIV_LAT);
        div_rd  <= bus.i_rd;
      end else if (div_cnt != '0) begin
        div_cnt <= div_cnt - CNT_W'(1);
      end
    end
  end

  assign bus.o_stall      = stall;
  assign bus.o_pipe_issue = pipe_issue;
  assign bus.o_div_issue  = div_issue;
  assign bus.o_div_busy   = (div_cnt != '0);
  assign bus.o_div_wb     = (div_cnt == CNT_W'(1));
  assign bus.o_div_rd     = div_rd;
  assign bus.o_pending    = haz_mask;

`ifdef FP_HAZ_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign bus.o_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_fp_hazard_u.sv
// tb/tb_fp_hazard_u.sv - directed scoreboard bench for fp_hazard_u
module tb_fp_hazard_u;
  import fp_pkg::*;

  localparam int DIV_LAT  = 12;
  localparam int SQRT_LAT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_hazard_u_if bus ();

  fp_hazard_u #(.PIPE_LAT(3), .DIV_LAT(DIV_LAT), .SQRT_LAT(SQRT_LAT)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int exp_stalls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic        s;
    logic        pi;
    logic        di;
    logic        busy;
    logic [31:0] pend;
  } exp_t;

  typedef struct {
    int         at;
    logic [4:0] rd;
  } wb_t;

  exp_t sbq[$];
  wb_t  dq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push the expectation for the current cycle, compare mid-cycle, advance.
  task automatic cyc_chk(input string tag, input logic s, input logic pi,
                         input logic di, input logic busy, input logic [31:0] pend);
    exp_t e;
    e.tag = tag; e.s = s; e.pi = pi; e.di = di; e.busy = busy; e.pend = pend;
    sbq.push_back(e);
    if (s) exp_stalls++;
    @(negedge clk);
    e = sbq.pop_front();
    chk({e.tag, "_stall"},   {31'b0, bus.o_stall},      {31'b0, e.s});
    chk({e.tag, "_pissue"},  {31'b0, bus.o_pipe_issue}, {31'b0, e.pi});
    chk({e.tag, "_dissue"},  {31'b0, bus.o_div_issue},  {31'b0, e.di});
    chk({e.tag, "_busy"},    {31'b0, bus.o_div_busy},   {31'b0, e.busy});
    chk({e.tag, "_pending"}, bus.o_pending,             e.pend);
    @(posedge clk);
    #1;
  endtask

  // Every divider WB must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wb_t w;
    if (bus.o_div_wb === 1'b1) begin
      if (dq.size() == 0) begin
        chk("div_wb_spurious", 32'd1, 32'd0);
      end else begin
        w = dq.pop_front();
        chk("div_wb_cycle", cyc, w.at);
        chk("div_wb_rd", {27'b0, bus.o_div_rd}, {27'b0, w.rd});
      end
    end
  end

  task automatic ins(input logic [6:0] op, input logic [6:0] f7, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [4:0] r3, input logic [4:0] rd,
                     input logic fl);
    bus.i_id_valid = 1'b1;
    bus.i_flush    = fl;
    bus.i_opcode   = op;
    bus.i_funct7   = f7;
    bus.i_rs1      = r1;
    bus.i_rs2      = r2;
    bus.i_rs3      = r3;
    bus.i_rd       = rd;
  endtask

  task automatic idle();
    bus.i_id_valid = 1'b0;
    bus.i_flush    = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    ins(OP_FP, F7_FADD, 0, 0, 0, 0, 0);
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc_chk("rst", 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    chk("rst_div_rd", {27'b0, bus.o_div_rd}, 32'd0);
    chk("rst_div_wb", {31'b0, bus.o_div_wb}, 32'd0);
    @(posedge clk);
    #1;

    // FMUL f3 then dependent FADD
    ins(OP_FP, F7_FMUL, 1, 2, 0, 3, 0);  cyc_chk("s1_fmul", 0, 1, 0, 0, 32'h0);
    ins(OP_FP, F7_FADD, 1, 3, 0, 4, 0);  cyc_chk("s1_raw_a", 1, 0, 0, 0, 32'h8);
    cyc_chk("s1_raw_b", 1, 0, 0, 0, 32'h8);
    cyc_chk("s1_go", 0, 1, 0, 0, 32'h0);
    idle();
    cyc_chk("s1_d1", 0, 0, 0, 0, 32'h10);
    cyc_chk("s1_d2", 0, 0, 0, 0, 32'h10);
    cyc_chk("s1_d3", 0, 0, 0, 0, 32'h0);

    // FDIV f5, FSQRT waits for the WB cycle then reloads
    ins(OP_FP, F7_FDIV, 1, 2, 0, 5, 0);
    dq.push_back('{cyc + DIV_LAT, 5'd5});
    cyc_chk("s2_fdiv", 0, 0, 1, 0, 32'h0);
    ins(OP_FP, F7_FSQRT, 7, 0, 0, 6, 0);
    for (int i = 1; i <= 11; i++) cyc_chk("s2_sqrt_stall", 1, 0, 0, 1, 32'h20);
    dq.push_back('{cyc + SQRT_LAT, 5'd6});
    cyc_chk("s2_sqrt_go", 0, 0, 1, 1, 32'h0);
    idle();
    for (int i = 13; i <= 27; i++) cyc_chk("s2_sqrt_busy", 0, 0, 0, 1, 32'h40);

    // FDIV on the FSQRT WB cycle; FADD at cnt=PIPE_LAT+1 takes one stall
    ins(OP_FP, F7_FDIV, 1, 2, 0, 8, 0);
    dq.push_back('{cyc + DIV_LAT, 5'd8});
    cyc_chk("s3_fdiv_on_wb", 0, 0, 1, 1, 32'h0);
    idle();
    for (int i = 1; i <= 8; i++) cyc_chk("s3_busy", 0, 0, 0, 1, 32'h100);
    ins(OP_FP, F7_FADD, 1, 2, 0, 7, 0);  cyc_chk("s3_port", 1, 0, 0, 1, 32'h100);
    cyc_chk("s3_pipe_go", 0, 1, 0, 1, 32'h100);
    idle();
    cyc_chk("s3_c11", 0, 0, 0, 1, 32'h180);
    cyc_chk("s3_c12", 0, 0, 0, 1, 32'h80);
    cyc_chk("s3_c13", 0, 0, 0, 0, 32'h0);

    // Operand-use exclusions, WAW and flush
    ins(OP_FP, F7_FMUL, 1, 2, 0, 3, 0);      cyc_chk("s4_fmul_a", 0, 1, 0, 0, 32'h0);
    ins(OP_FP, F7_FCVT_S_W, 3, 0, 0, 9, 0);  cyc_chk("s4_fcvt_int_rs1", 0, 0, 0, 0, 32'h8);
    ins(OP_FSW, 7'h0, 3, 10, 0, 0, 0);       cyc_chk("s4_fsw_int_rs1", 0, 0, 0, 0, 32'h8);
    ins(OP_FP, F7_FMUL, 1, 2, 0, 3, 0);      cyc_chk("s4_fmul_b", 0, 1, 0, 0, 32'h0);
    ins(OP_FSW, 7'h0, 4, 3, 0, 0, 0);        cyc_chk("s4_fsw_rs2_a", 1, 0, 0, 0, 32'h8);
    cyc_chk("s4_fsw_rs2_b", 1, 0, 0, 0, 32'h8);
    cyc_chk("s4_fsw_go", 0, 0, 0, 0, 32'h0);
    ins(OP_FP, F7_FMUL, 1, 2, 0, 3, 0);      cyc_chk("s4_fmul_c", 0, 1, 0, 0, 32'h0);
    ins(OP_FLW, 7'h0, 1, 0, 0, 3, 0);        cyc_chk("s4_flw_waw", 1, 0, 0, 0, 32'h8);
    ins(OP_FLW, 7'h0, 1, 0, 0, 3, 1);        cyc_chk("s4_flw_flush", 0, 0, 0, 0, 32'h8);
    ins(OP_FLW, 7'h0, 1, 0, 0, 3, 0);        cyc_chk("s4_flw_at_wb", 0, 0, 0, 0, 32'h0);
    ins(OP_FP, F7_FMUL, 1, 2, 0, 3, 0);      cyc_chk("s4_fmul_d", 0, 1, 0, 0, 32'h0);
    ins(OP_FMADD, 7'h0, 1, 2, 3, 12, 0);     cyc_chk("s4_fma_rs3_a", 1, 0, 0, 0, 32'h8);
    cyc_chk("s4_fma_rs3_b", 1, 0, 0, 0, 32'h8);
    cyc_chk("s4_fma_go", 0, 1, 0, 0, 32'h0);
    idle();
    cyc_chk("s4_d1", 0, 0, 0, 0, 32'h1000);
    cyc_chk("s4_d2", 0, 0, 0, 0, 32'h1000);
    cyc_chk("s4_d3", 0, 0, 0, 0, 32'h0);
`ifdef FP_HAZ_PERF_EN
    @(negedge clk);
    chk("stall_cnt", bus.o_stall_cnt, exp_stalls);
    @(posedge clk);
    #1;
`endif

    // Reset during a divide aborts it; no WB may follow
    ins(OP_FP, F7_FDIV, 1, 2, 0, 5, 0);  cyc_chk("s5_fdiv", 0, 0, 1, 0, 32'h0);
    idle();
    for (int i = 1; i <= 4; i++) cyc_chk("s5_busy", 0, 0, 0, 1, 32'h20);
    rst = 1'b1;
    cyc_chk("s5_rst_cycle", 0, 0, 0, 1, 32'h20);
    rst = 1'b0;
    exp_stalls = 0;
    ins(OP_FP, F7_FADD, 5, 2, 0, 11, 0); cyc_chk("s5_after_rst", 0, 1, 0, 0, 32'h0);
    idle();
    @(negedge clk);
    chk("s5_div_rd", {27'b0, bus.o_div_rd}, 32'd0);
`ifdef FP_HAZ_PERF_EN
    chk("s5_stall_cnt", bus.o_stall_cnt, exp_stalls);
`endif
    @(posedge clk);
    #1;
    cyc_chk("s5_c8", 0, 0, 0, 0, 32'h800);
    for (int i = 9; i <= 20; i++) cyc_chk("s5_quiet", 0, 0, 0, 0, 32'h0);

    chk("div_wb_all_seen", dq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
